// File: rtl/cdc_pkg.sv
// Shared types and defaults for the toggle-handshake clock-domain crossing blocks.
package cdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } hs_rx_state_t;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage : cdc_pkg

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Shared by the handshake receiver (request) and transmitter (acknowledge).
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_async_in,
    output logic q_sync_out
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async_in};
        end
    end

    assign q_sync_out = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/cdc_handshake_rx.sv
// Destination endpoint of a two-phase req/ack crossing: captures the source-held
// word once per request toggle and returns the ack toggle only after downstream accepts.
module cdc_handshake_rx
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req_async_in,
    input  logic [WIDTH-1:0] data_async_in,
    output logic             ack_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [15:0]      xfer_count_out
);

    hs_rx_state_t      state_q;
    hs_rx_state_t      state_d;
    logic              req_sync;
    logic              req_seen_q;
    logic              ack_q;
    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [15:0]       count_q;
    logic              capture;
    logic              accept;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .d_async_in (req_async_in),
        .q_sync_out (req_sync)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A toggle arriving while FULL stays visible as req_sync != req_seen_q until IDLE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_sync != req_seen_q) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (ready_in) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // data_async_in is only sampled on the capture cycle; it is quasi-static otherwise.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            if (capture) begin
                data_q     <= data_async_in;
                req_seen_q <= req_sync;
                valid_q    <= 1'b1;
            end
            if (accept) begin
                ack_q   <= ~ack_q;
                valid_q <= 1'b0;
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign ack_out        = ack_q;
    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign xfer_count_out = count_q;

endmodule : cdc_handshake_rx

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx: latency, backpressure, streaming, reset, wrap, deep sync.
module tb_cdc_handshake_rx;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [7:0]  data;
    logic        ready;
    logic        ack;
    logic [7:0]  dout;
    logic        valid;
    logic [15:0] count;

    logic        req3;
    logic [7:0]  data3;
    logic        ready3;
    logic        ack3;
    logic [7:0]  dout3;
    logic        valid3;
    logic [15:0] count3;

    int tests;
    int errors;

    cdc_handshake_rx #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .req_async_in   (req),
        .data_async_in  (data),
        .ack_out        (ack),
        .data_out       (dout),
        .valid_out      (valid),
        .ready_in       (ready),
        .xfer_count_out (count)
    );

    cdc_handshake_rx #(
        .WIDTH       (8),
        .SYNC_STAGES (3)
    ) dut3 (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .req_async_in   (req3),
        .data_async_in  (data3),
        .ack_out        (ack3),
        .data_out       (dout3),
        .valid_out      (valid3),
        .ready_in       (ready3),
        .xfer_count_out (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; data = 8'h00; ready = 1'b0;
        req3 = 1'b0; data3 = 8'h00; ready3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ack, valid, dout, count} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got ack=%b valid=%b data=%h count=%h, expected all 0", ack, valid, dout, count);
        end
        tests++;
        if ({ack3, valid3, dout3, count3} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state_s3: got ack=%b valid=%b data=%h count=%h, expected all 0", ack3, valid3, dout3, count3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) edge_sample();
        tests++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid got %b expected 0", valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        data = 8'hA5; ready = 1'b1; req = 1'b1;
        for (int e = 0; e < 2; e++) begin
            edge_sample();
            tests++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL single_early_valid: E%0d valid got %b expected 0", e, valid);
            end
        end
        edge_sample();
        tests++;
        if (valid !== 1'b1 || dout !== 8'hA5 || ack !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: valid=%b data=%h ack=%b, expected valid=1 data=a5 ack=0", valid, dout, ack);
        end
        edge_sample();
        tests++;
        if (valid !== 1'b0 || ack !== 1'b1 || count !== 16'd1) begin
            errors++;
            $display("FAIL single_accept: valid=%b ack=%b count=%0d, expected valid=0 ack=1 count=1", valid, ack, count);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ready = 1'b0; data = 8'hA5; req = 1'b0;
        repeat (3) edge_sample();
        tests++;
        if (valid !== 1'b1 || dout !== 8'hA5) begin
            errors++;
            $display("FAIL bp_capture: valid=%b data=%h, expected valid=1 data=a5", valid, dout);
        end
        data = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            edge_sample();
            tests++;
            if (valid !== 1'b1 || dout !== 8'hA5 || ack !== 1'b1 || count !== 16'd1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%h ack=%b count=%0d, expected 1/a5/1/1", c, valid, dout, ack, count);
            end
        end
        @(negedge clk);
        ready = 1'b1;
        edge_sample();
        tests++;
        if (valid !== 1'b0 || ack !== 1'b0 || count !== 16'd2) begin
            errors++;
            $display("FAIL bp_release: valid=%b ack=%b count=%0d, expected 0/0/2", valid, ack, count);
        end
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   exp_word;
        int   sent;
        int   ack_toggles;
        int   cycles;
        logic ack_prev;
        exp_word = 0; sent = 0; ack_toggles = 0; cycles = 0;
        ack_prev = ack;
        @(negedge clk);
        data = 8'h00; req = ~req; sent = 1;
        while (ack_toggles < 16 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            ready = 1'($urandom_range(0, 1));
            #1;
            if (valid === 1'b1 && ready === 1'b1) begin
                tests++;
                if (dout !== 8'(exp_word)) begin
                    errors++;
                    $display("FAIL b2b_word: got %h expected %h", dout, 8'(exp_word));
                end
                exp_word++;
            end
            if (ack !== ack_prev) begin
                ack_prev = ack;
                ack_toggles++;
                if (sent < 16) begin
                    data = 8'(sent);
                    req = ~req;
                    sent++;
                end
            end
        end
        ready = 1'b0;
        tests++;
        if (cycles >= 2000) begin
            errors++;
            $display("FAIL b2b_timeout: ack toggles got %0d expected 16 within 2000 cycles", ack_toggles);
        end
        tests++;
        if (exp_word != 16) begin
            errors++;
            $display("FAIL b2b_delivered: got %0d words expected 16", exp_word);
        end
        tests++;
        if (count !== 16'd18) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 18", count);
        end
        repeat (4) edge_sample();
        tests++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_duplicate: valid got %b expected 0", valid);
        end
    endtask

    task automatic test_reset_mid_full();
        @(negedge clk);
        ready = 1'b0; data = 8'h3C; req = ~req;
        repeat (3) edge_sample();
        tests++;
        if (valid !== 1'b1 || dout !== 8'h3C) begin
            errors++;
            $display("FAIL rst_pre_full: valid=%b data=%h, expected 1/3c", valid, dout);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ack, valid, dout, count} !== 26'd0) begin
            errors++;
            $display("FAIL rst_async_clear: ack=%b valid=%b data=%h count=%h, expected all 0", ack, valid, dout, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 2; e++) begin
            edge_sample();
            tests++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_early_valid: E%0d valid got %b expected 0", e, valid);
            end
        end
        edge_sample();
        tests++;
        if (valid !== 1'b1 || dout !== 8'h3C || ack !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL rst_recapture: valid=%b data=%h ack=%b count=%0d, expected 1/3c/0/0", valid, dout, ack, count);
        end
        @(negedge clk);
        ready = 1'b1;
        edge_sample();
        tests++;
        if (valid !== 1'b0 || ack !== 1'b1 || count !== 16'd1) begin
            errors++;
            $display("FAIL rst_accept: valid=%b ack=%b count=%0d, expected 0/1/1", valid, ack, count);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        ready = 1'b1;
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        #1;
        tests++;
        if (count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected ffff", count);
        end
        data = 8'h5A; req = ~req;
        repeat (3) edge_sample();
        tests++;
        if (valid !== 1'b1 || dout !== 8'h5A) begin
            errors++;
            $display("FAIL wrap_capture: valid=%b data=%h, expected 1/5a", valid, dout);
        end
        edge_sample();
        tests++;
        if (count !== 16'h0000 || ack !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count: count=%h ack=%b, expected 0000/0", count, ack);
        end
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_sync3();
        @(negedge clk);
        data3 = 8'hA5; ready3 = 1'b1; req3 = 1'b1;
        for (int e = 0; e < 3; e++) begin
            edge_sample();
            tests++;
            if (valid3 !== 1'b0) begin
                errors++;
                $display("FAIL s3_early_valid: E%0d valid got %b expected 0", e, valid3);
            end
        end
        edge_sample();
        tests++;
        if (valid3 !== 1'b1 || dout3 !== 8'hA5 || ack3 !== 1'b0) begin
            errors++;
            $display("FAIL s3_capture: valid=%b data=%h ack=%b, expected 1/a5/0", valid3, dout3, ack3);
        end
        edge_sample();
        tests++;
        if (valid3 !== 1'b0 || ack3 !== 1'b1 || count3 !== 16'd1) begin
            errors++;
            $display("FAIL s3_accept: valid=%b ack=%b count=%0d, expected 0/1/1", valid3, ack3, count3);
        end
    endtask

    initial begin
        tests = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_full();
        test_counter_wrap();
        test_sync3();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule : tb_cdc_handshake_rx
